spi_flash_boot_loader: RTL and testbench
========================================

// Module: spi_flash_boot_loader
// PURPOSE
//  Boot-time copier: after start, drives the SPI flash directly with a single-lane READ (0x03) command.
//  Streams WORD_COUNT 32-bit words from a flash byte address into on-chip RAM through a simple write port.
//  Sits beside apb_spi_master on the flash CS0/SCK/SI/SO pins (pin mux outside) and upstream of axi_ram.
//  Used to load main.hex from flash instead of $readmemh.
// PARAMETERS
//  CLK_DIV     2     clk cycles per SCK half-period (>=1); SCK = clk/(2*CLK_DIV)
//  ADDR_W      24    flash byte-address width (3-byte addressing)
//  MEM_AW      16    RAM word-address width
//  CNT_W       16    word-count width
//  CS_GAP      4     clk cycles CSn held high after transfer before done
// PORTS
//  clk         in   1       system clock
//  rst         in   1       synchronous, active-high reset
//  start       in   1       1-cycle pulse; sampled only in IDLE
//  flash_addr  in   ADDR_W  first flash byte address (latched on start)
//  mem_base    in   MEM_AW  first RAM word address (latched on start)
//  word_count  in   CNT_W   number of 32-bit words (latched on start)
//  busy        out  1       high from start acceptance until done
//  done        out  1       1-cycle pulse at end of transfer
//  spi_clk     out  1       SCK, idle low (mode 0)
//  spi_csn     out  1       chip select, active low
//  spi_sdo     out  1       to flash SI
//  spi_sdi     in   1       from flash SO
//  mem_we      out  1       RAM write request
//  mem_addr    out  MEM_AW  RAM word address
//  mem_wdata   out  32      RAM write data
//  mem_ready   in   1       RAM accepts write when mem_we&&mem_ready
// BEHAVIOUR
//  Reset: busy=0 done=0 spi_clk=0 spi_csn=1 spi_sdo=0 mem_we=0 mem_addr=0 mem_wdata=0; FSM->IDLE.
//  Reset mid-transfer: all outputs return to reset values next cycle; partial word discarded.
//  FSM: IDLE -> CS_SETUP -> CMD -> ADDR -> DATA <-> WRITE -> CS_HOLD -> DONE -> IDLE.
//  IDLE: start=1 latches inputs, busy=1; if word_count==0 go directly DONE (CSn never asserted).
//  CS_SETUP: spi_csn=0, spi_sdo=MSB of 0x03, wait CLK_DIV cycles.
//  CMD/ADDR/DATA: mode 0, MSB first; SCK toggles every CLK_DIV cycles;
//   spi_sdi sampled in the cycle SCK rises; spi_sdo updated in the cycle SCK falls.
//  CMD: 8 bits 0x03; ADDR: ADDR_W bits flash_addr; DATA: 32 bits, spi_sdo=0.
//  Byte assembly little-endian: first received byte -> mem_wdata[7:0], 4th -> [31:24].
//  After the 32nd SCK rising edge: SCK returns low after CLK_DIV cycles, enter WRITE.
//  WRITE: mem_we=1 with stable addr/data until mem_ready=1; SCK held low, CSn held low (flash stalls).
//   On accept: mem_addr+1 (wraps mod 2^MEM_AW), remaining-1; remaining!=0 -> DATA, else CS_HOLD.
//  No further SCK edges while mem_we pending; flash address continues sequentially (no re-command).
//  CS_HOLD: spi_csn=1 for CS_GAP cycles. DONE: done=1 for 1 cycle, busy=0 in same cycle, -> IDLE.
//  start while busy is ignored. Flash address wrap is flash-defined; block does not check it.
//  Total SCK cycles per transfer = 8 + ADDR_W + 32*word_count.
// TESTING
//  1. Flash model preloaded 0x000100: 11 22 33 44; start addr=0x000100 base=0x0000 count=1
//     -> SI carries 0x03,0x000100; one write mem_addr=0, mem_wdata=0x44332211; done after CSn high 4 clk.
//  2. count=4, mem_ready tied 1 -> 4 writes at addr 0..3, CSn low continuously, 8+24+128 SCK rises.
//  3. count=2, mem_ready low 10 cycles on first write -> mem_we/data stable, SCK low stalled, data correct.
//  4. count=0 start -> busy 1 cycle, done pulse, spi_csn never 0, no mem_we.
//  5. rst asserted during ADDR phase -> next cycle csn=1 sck=0 busy=0; new start completes correctly.
//  6. mem_base=0xFFFF count=2 -> writes at 0xFFFF then 0x0000; start pulse while busy ignored.

Source files
------------

// File: rtl/spi_flash_boot_loader.sv
// spi_flash_boot_loader: copies WORD_COUNT words from SPI flash (READ 0x03) into RAM at boot
module spi_flash_boot_loader #(
  parameter int CLK_DIV = 2,
  parameter int ADDR_W  = 24,
  parameter int MEM_AW  = 16,
  parameter int CNT_W   = 16,
  parameter int CS_GAP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] flash_addr,
  input  logic [MEM_AW-1:0] mem_base,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              spi_clk,
  output logic              spi_csn,
  output logic              spi_sdo,
  input  logic              spi_sdi,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready
);
  localparam int TW = 8 + ADDR_W;
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_M1 = 16'(CS_GAP - 1);
  localparam logic [7:0]  AD_END = 8'(TW);
  typedef enum logic [2:0] {IDLE, CS_SETUP, CMD, ADDR, DATA, WRITE, CS_HOLD, DONE} state_t;
  state_t state;
  logic [15:0]      cnt;
  logic [7:0]       bits;
  logic [TW-1:0]    tx;
  logic [31:0]      rx;
  logic [CNT_W-1:0] rem;
  logic             tick;
  assign tick = cnt == DIV_M1;
  // transfer sequencer: SCK divider, command/address shift-out, data shift-in, RAM write handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      spi_clk   <= 1'b0;
      spi_csn   <= 1'b1;
      spi_sdo   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
      bits      <= '0;
      tx        <= '0;
      rx        <= '0;
      rem       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy     <= 1'b1;
          mem_addr <= mem_base;
          rem      <= word_count;
          tx       <= {8'h03, flash_addr};
          cnt      <= '0;
          bits     <= '0;
          if (word_count == '0) state <= DONE;
          else begin
            state   <= CS_SETUP;
            spi_csn <= 1'b0;
            spi_sdo <= 1'b0;
          end
        end
        CS_SETUP: begin
          cnt <= tick ? '0 : cnt + 16'd1;
          if (tick) state <= CMD;
        end
        CMD, ADDR, DATA: begin
          cnt <= tick ? '0 : cnt + 16'd1;
          if (tick) begin
            spi_clk <= ~spi_clk;
            if (!spi_clk) begin
              rx   <= {rx[30:0], spi_sdi};
              bits <= bits + 8'd1;
            end else begin
              spi_sdo <= tx[TW-2];
              tx      <= tx << 1;
              if (state == CMD && bits == 8'd8) state <= ADDR;
              if (state == ADDR && bits == AD_END) begin
                state <= DATA;
                bits  <= '0;
              end
              if (state == DATA && bits == 8'd32) begin
                state     <= WRITE;
                mem_we    <= 1'b1;
                mem_wdata <= {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
              end
            end
          end
        end
        WRITE: if (mem_ready) begin
          mem_we   <= 1'b0;
          mem_addr <= mem_addr + MEM_AW'(1);
          rem      <= rem - CNT_W'(1);
          bits     <= '0;
          cnt      <= '0;
          if (rem == CNT_W'(1)) begin
            state   <= CS_HOLD;
            spi_csn <= 1'b1;
          end else state <= DATA;
        end
        CS_HOLD: begin
          cnt <= cnt + 16'd1;
          if (cnt == GAP_M1) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          done  <= busy;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_boot_loader.sv
// tb_spi_flash_boot_loader: flash model plus write scoreboard around spi_flash_boot_loader
module tb_spi_flash_boot_loader;
  localparam int ADDR_W = 24;
  localparam int CS_GAP = 4;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [23:0] flash_addr = '0;
  logic [15:0] mem_base = '0, word_count = '0;
  logic        busy, done, spi_clk, spi_csn, spi_sdo, mem_we;
  logic        spi_sdi = 1'b0, mem_ready = 1'b1;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  typedef struct {logic [15:0] a; logic [31:0] d;} wr_t;
  wr_t q[$];
  int n_checks = 0, n_fail = 0;
  int rises = 0, csn_rises = 0, csn_run = 0, nwrites = 0, rx_cnt = 0, dbit = 0;
  logic csn_low_seen = 1'b0, chk_gap = 1'b0;
  logic [31:0] cmd_addr = '0, exp_cmd = '0;
  logic [7:0] fmem [0:4095];

  spi_flash_boot_loader dut (
    .clk(clk), .rst(rst), .start(start), .flash_addr(flash_addr), .mem_base(mem_base),
    .word_count(word_count), .busy(busy), .done(done), .spi_clk(spi_clk), .spi_csn(spi_csn),
    .spi_sdo(spi_sdo), .spi_sdi(spi_sdi), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode-0 flash: captures command+address on SCK rise, streams bytes MSB first after each fall
  always @(posedge spi_clk, negedge spi_clk, posedge spi_csn) begin
    if (spi_csn) begin
      rx_cnt = 0;
      dbit = 0;
    end else if (spi_clk) begin
      if (rx_cnt < 32) cmd_addr = {cmd_addr[30:0], spi_sdo};
      rx_cnt++;
      if (rx_cnt == 32) check("cmd_addr", cmd_addr, exp_cmd);
    end else if (rx_cnt >= 32) begin
      spi_sdi = fmem[12'(cmd_addr[11:0] + dbit / 8)][7 - dbit % 8];
      dbit++;
    end
  end

  always @(posedge spi_clk) rises++;
  always @(posedge spi_csn) csn_rises++;

  // write scoreboard and CSn-gap monitor
  always @(negedge clk) begin
    if (mem_we) begin
      check("sck_low_wr", 64'(spi_clk), 64'd0);
      if (q.size() > 0) begin
        check("wr_addr", 64'(mem_addr), 64'(q[0].a));
        check("wr_data", 64'(mem_wdata), 64'(q[0].d));
      end
      if (mem_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        nwrites++;
      end
    end
    if (done && chk_gap) check("cs_gap", 64'(csn_run), 64'(CS_GAP));
    csn_run = spi_csn ? csn_run + 1 : 0;
    if (!spi_csn) csn_low_seen = 1'b1;
  end

  task automatic xfer(input logic [23:0] fa, input logic [15:0] mb, input logic [15:0] wc,
                      input int stall, input bit extra_start);
    int t;
    logic [11:0] a;
    rises = 0; csn_rises = 0; nwrites = 0; csn_low_seen = 1'b0;
    exp_cmd = {8'h03, fa};
    for (int i = 0; i < int'(wc); i++) begin
      a = 12'(fa + 24'(4 * i));
      q.push_back('{16'(mb + 16'(i)), {fmem[a + 12'd3], fmem[a + 12'd2], fmem[a + 12'd1], fmem[a]}});
    end
    chk_gap = wc != 0;
    mem_ready = stall == 0;
    @(posedge clk); #1;
    flash_addr = fa; mem_base = mb; word_count = wc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_acc", 64'(busy), 64'd1);
    if (stall > 0) begin
      t = 0;
      while (!mem_we && t < 5000) begin @(posedge clk); #1; t++; end
      check("we_seen", 64'(mem_we), 64'd1);
      repeat (stall) @(posedge clk);
      #1 mem_ready = 1'b1;
    end
    if (extra_start) begin
      repeat (20) @(posedge clk);
      #1 flash_addr = 24'h0; word_count = 16'd5; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    t = 0;
    while (!done && t < 20000) begin @(negedge clk); t++; end
    check("done_seen", 64'(done), 64'd1);
    check("busy_done", 64'(busy), 64'd0);
    check("nwrites", 64'(nwrites), 64'(wc));
    check("q_empty", 64'(q.size()), 64'd0);
    if (wc != 0) check("sck_rises", 64'(rises), 64'(8 + ADDR_W + 32 * int'(wc)));
    check("csn_rises", 64'(csn_rises), 64'(wc != 0));
    check("csn_low", 64'(csn_low_seen), 64'(wc != 0));
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'd0);
    chk_gap = 1'b0;
    q.delete();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 4096; i++) fmem[i] = 8'(i * 37 + 5);
    fmem[12'h100] = 8'h11; fmem[12'h101] = 8'h22; fmem[12'h102] = 8'h33; fmem[12'h103] = 8'h44;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sck", 64'(spi_clk), 64'd0);
    check("rst_csn", 64'(spi_csn), 64'd1);
    check("rst_sdo", 64'(spi_sdo), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b0;
    xfer(24'h000100, 16'h0000, 16'd1, 0, 1'b0);
    xfer(24'h000200, 16'h0010, 16'd4, 0, 1'b0);
    xfer(24'h000300, 16'h0040, 16'd2, 10, 1'b0);
    xfer(24'h000400, 16'h0000, 16'd0, 0, 1'b0);
    rises = 0;
    exp_cmd = 32'h03000500;
    @(posedge clk); #1;
    flash_addr = 24'h000500; mem_base = 16'h0080; word_count = 16'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t = 0;
    while (rises < 16 && t < 5000) begin @(posedge clk); #1; t++; end
    check("addr_phase", 64'(rises), 64'd16);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_csn", 64'(spi_csn), 64'd1);
    check("mid_rst_sck", 64'(spi_clk), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_we", 64'(mem_we), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    xfer(24'h000500, 16'h0080, 16'd1, 0, 1'b0);
    xfer(24'h000600, 16'hFFFF, 16'd2, 0, 1'b1);
    repeat (30) @(posedge clk);
    #1 check("ignored_start", 64'(busy), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
